// File: rtl/lut_neuron_pipe_pkg.sv
// lut_neuron_pipe_pkg: shared FSM encoding and table geometry helpers
package lut_neuron_pipe_pkg;
    typedef enum logic [1:0] {EMPTY, LOADING, RUN} state_t;
    localparam int MAX_ADDR_W = 12;
    function automatic int addr_w(input int fan_in, input int in_bits);
        return fan_in * in_bits;
    endfunction
    function automatic int depth(input int fan_in, input int in_bits);
        return 2 ** addr_w(fan_in, in_bits);
    endfunction
endpackage

// File: rtl/lut_neuron_pipe_if.sv
// lut_neuron_pipe_if: table-load, input and output handshake bundle
interface lut_neuron_pipe_if #(
    parameter int FAN_IN = 4,
    parameter int IN_BITS = 2,
    parameter int OUT_BITS = 2
);
    import lut_neuron_pipe_pkg::*;
    localparam int ADDR_W = addr_w(FAN_IN, IN_BITS);
    logic cfg_start;
    logic cfg_valid;
    logic [OUT_BITS-1:0] cfg_data;
    logic cfg_done;
    logic in_valid;
    logic in_ready;
    logic [ADDR_W-1:0] in_data;
    logic out_valid;
    logic out_ready;
    logic [OUT_BITS-1:0] out_data;
    modport master (
        output cfg_start, cfg_valid, cfg_data, in_valid, in_data, out_ready,
        input cfg_done, in_ready, out_valid, out_data
    );
    modport slave (
        input cfg_start, cfg_valid, cfg_data, in_valid, in_data, out_ready,
        output cfg_done, in_ready, out_valid, out_data
    );
endinterface

// File: rtl/lut_neuron_pipe_table.sv
// lut_table_ram: sync-write, async-read table storage with no reset
module lut_table_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 2
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    always_ff @(posedge clk)
        if (i_we) r_mem[i_waddr] <= i_wdata;
    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/lut_neuron_pipe.sv
// lut_neuron_pipe: LUT neuron with streamed table load and a two-stage output pipeline
module lut_neuron_pipe
    import lut_neuron_pipe_pkg::*;
#(
    parameter int FAN_IN = 4,
    parameter int IN_BITS = 2,
    parameter int OUT_BITS = 2
) (
    input logic clk,
    input logic rst,
    lut_neuron_pipe_if.slave bus
);
    localparam int ADDR_W = addr_w(FAN_IN, IN_BITS);
    if (ADDR_W > MAX_ADDR_W) begin : g_addr_chk
        $error("lut_neuron_pipe: ADDR_W %0d exceeds %0d", ADDR_W, MAX_ADDR_W);
    end
    state_t r_state, w_next;
    logic [ADDR_W-1:0] r_ptr, r_s1_addr;
    logic r_s1_valid, r_s2_valid;
    logic [OUT_BITS-1:0] r_s2_data, w_rdata;
    logic w_we, w_en, w_last;
    assign w_last = &r_ptr;
    always_ff @(posedge clk)
        if (rst) r_state <= EMPTY;
        else r_state <= w_next;
    // cfg_start wins over completing the final write
    always_comb
        w_next = bus.cfg_start ? LOADING : (w_we && w_last) ? RUN : r_state;
    always_comb begin
        w_we = r_state == LOADING && bus.cfg_valid && !bus.cfg_start;
        w_en = !r_s2_valid || bus.out_ready;
        bus.cfg_done = r_state == RUN;
        bus.in_ready = r_state == RUN && w_en;
    end
    always_ff @(posedge clk)
        if (rst || bus.cfg_start) r_ptr <= '0;
        else if (w_we && !w_last) r_ptr <= r_ptr + 1'b1;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s1_addr <= '0;
            r_s2_data <= '0;
        end else if (bus.cfg_start) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else if (w_en) begin
            r_s1_valid <= bus.in_valid && bus.in_ready;
            r_s1_addr <= bus.in_data;
            r_s2_valid <= r_s1_valid;
            r_s2_data <= w_rdata;
        end
    end
    assign bus.out_valid = r_s2_valid;
    assign bus.out_data = r_s2_data;
    lut_table_ram #(.ADDR_W(ADDR_W), .DATA_W(OUT_BITS)) u_ram (
        .clk(clk),
        .i_we(w_we),
        .i_waddr(r_ptr),
        .i_wdata(bus.cfg_data),
        .i_raddr(r_s1_addr),
        .o_rdata(w_rdata)
    );
endmodule

// File: tb/tb_lut_neuron_pipe.sv
// tb_lut_neuron_pipe: directed checks on the default build plus a scoreboarded 3x3->4 build
module tb_lut_neuron_pipe;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    lut_neuron_pipe_if b ();
    lut_neuron_pipe_if #(.FAN_IN(3), .IN_BITS(3), .OUT_BITS(4)) b2 ();
    lut_neuron_pipe dut (.clk(clk), .rst(rst), .bus(b));
    lut_neuron_pipe #(.FAN_IN(3), .IN_BITS(3), .OUT_BITS(4)) dut2 (.clk(clk), .rst(rst), .bus(b2));
    task automatic nxt();
        @(negedge clk);
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    // start cycle carries junk data with cfg_valid=1 so a non-ignored write shifts the table
    task automatic load(input bit inv, input int n);
        logic [7:0] av;
        b.cfg_start = 1'b1;
        b.cfg_valid = 1'b1;
        b.cfg_data = 2'b10;
        nxt();
        b.cfg_start = 1'b0;
        for (int a = 0; a < n; a++) begin
            av = 8'(a);
            b.cfg_data = inv ? ~av[1:0] : av[1:0];
            if (a == 255) begin
                #1;
                chk("load_last_done", b.cfg_done, 0);
                chk("load_last_rdy", b.in_ready, 0);
            end
            nxt();
        end
        b.cfg_valid = 1'b0;
    endtask
    logic [7:0] w5 [5] = '{8'h01, 8'h02, 8'h03, 8'h00, 8'h05};
    logic [1:0] e5 [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [1:0] got [$];
    logic [1:0] g;
    logic [3:0] tbl2 [512];
    logic [3:0] q [$];
    logic [3:0] e;
    int sent;
    initial begin
        {b.cfg_start, b.cfg_valid, b.cfg_data, b.in_valid, b.in_data} = '0;
        {b2.cfg_start, b2.cfg_valid, b2.cfg_data, b2.in_valid, b2.in_data} = '0;
        b.out_ready = 1'b1;
        b2.out_ready = 1'b1;
        rst = 1'b1;
        nxt();
        nxt();
        #1;
        chk("rst_done", b.cfg_done, 0);
        chk("rst_rdy", b.in_ready, 0);
        chk("rst_ov", b.out_valid, 0);
        chk("rst_od", b.out_data, 0);
        rst = 1'b0;
        b.in_valid = 1'b1;
        b.in_data = 8'h55;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("preload_idle", {b.cfg_done, b.in_ready, b.out_valid}, 3'b000);
            nxt();
        end
        b.in_valid = 1'b0;
        load(1'b0, 256);
        #1;
        chk("load_done", b.cfg_done, 1);
        b.in_valid = 1'b1;
        b.in_data = 8'h00;
        #1;
        chk("b2b_rdy", b.in_ready, 1);
        nxt();
        b.in_data = 8'hA1;
        #1;
        chk("b2b_ov1", b.out_valid, 0);
        nxt();
        b.in_data = 8'hFF;
        #1;
        chk("b2b_ov2", b.out_valid, 1);
        chk("b2b_od2", b.out_data, 2'b00);
        nxt();
        b.in_valid = 1'b0;
        #1;
        chk("b2b_ov3", b.out_valid, 1);
        chk("b2b_od3", b.out_data, 2'b01);
        nxt();
        #1;
        chk("b2b_ov4", b.out_valid, 1);
        chk("b2b_od4", b.out_data, 2'b11);
        nxt();
        #1;
        chk("b2b_ov5", b.out_valid, 0);
        sent = 0;
        for (int c = 0; c < 16; c++) begin
            b.out_ready = !(c >= 3 && c <= 5);
            b.in_valid = sent < 5;
            b.in_data = w5[sent < 5 ? sent : 0];
            #1;
            if (c >= 3 && c <= 5) begin
                chk("stall_rdy", b.in_ready, 0);
                chk("stall_ov", b.out_valid, 1);
                chk("stall_hold", b.out_data, 2'b10);
            end
            if (b.in_valid && b.in_ready) sent++;
            if (b.out_valid && b.out_ready) got.push_back(b.out_data);
            nxt();
        end
        b.in_valid = 1'b0;
        b.out_ready = 1'b1;
        chk("stall_count", got.size(), 5);
        for (int i = 0; i < 5; i++) begin
            g = got.size() > i ? got[i] : 2'bx;
            chk("stall_order", g, e5[i]);
        end
        load(1'b1, 100);
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        #1;
        chk("rst_abandon", {b.cfg_done, b.in_ready, b.out_valid}, 3'b000);
        load(1'b1, 256);
        #1;
        chk("reload_done", b.cfg_done, 1);
        b.in_valid = 1'b1;
        b.in_data = 8'h02;
        nxt();
        b.in_valid = 1'b0;
        nxt();
        #1;
        chk("inv_ov", b.out_valid, 1);
        chk("inv_od", b.out_data, 2'b01);
        b.cfg_valid = 1'b1;
        b.cfg_data = 2'b11;
        nxt();
        nxt();
        nxt();
        nxt();
        b.cfg_valid = 1'b0;
        b.in_valid = 1'b1;
        b.in_data = 8'hFF;
        nxt();
        b.in_data = 8'h02;
        nxt();
        b.in_valid = 1'b0;
        #1;
        chk("ign_done", b.cfg_done, 1);
        chk("ign_od1", b.out_data, 2'b00);
        nxt();
        #1;
        chk("ign_od2", b.out_data, 2'b01);
        nxt();
        b.in_valid = 1'b1;
        b.in_data = 8'h03;
        nxt();
        b.in_data = 8'h00;
        nxt();
        b.in_valid = 1'b0;
        b.cfg_start = 1'b1;
        #1;
        chk("flight_ov", b.out_valid, 1);
        chk("flight_od", b.out_data, 2'b00);
        nxt();
        b.cfg_start = 1'b0;
        b.in_valid = 1'b1;
        b.in_data = 8'h03;
        #1;
        chk("flush_ov", b.out_valid, 0);
        chk("flush_rdy", b.in_ready, 0);
        chk("flush_done", b.cfg_done, 0);
        nxt();
        nxt();
        #1;
        chk("flush_ov2", b.out_valid, 0);
        load(1'b0, 256);
        #1;
        chk("new_done", b.cfg_done, 1);
        chk("new_rdy", b.in_ready, 1);
        nxt();
        b.in_valid = 1'b0;
        #1;
        chk("new_ov1", b.out_valid, 0);
        nxt();
        #1;
        chk("new_ov2", b.out_valid, 1);
        chk("new_od2", b.out_data, 2'b11);
        nxt();
        for (int a = 0; a < 512; a++) tbl2[a] = 4'($urandom);
        b2.cfg_start = 1'b1;
        nxt();
        b2.cfg_start = 1'b0;
        for (int a = 0; a < 512; a++) begin
            b2.cfg_valid = 1'b1;
            b2.cfg_data = tbl2[a];
            nxt();
        end
        b2.cfg_valid = 1'b0;
        #1;
        chk("sw_done", b2.cfg_done, 1);
        for (int c = 0; c < 1010; c++) begin
            b2.in_valid = c < 1000 ? 1'($urandom) : 1'b0;
            b2.in_data = 9'($urandom);
            b2.out_ready = c < 1000 ? ($urandom_range(3) != 0) : 1'b1;
            #1;
            if (b2.out_valid && b2.out_ready) begin
                e = q.size() != 0 ? q.pop_front() : 4'bx;
                chk("sw_data", b2.out_data, e);
            end
            if (b2.in_valid && b2.in_ready) q.push_back(tbl2[b2.in_data]);
            nxt();
        end
        chk("sw_drain", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
